mvm_loader: RTL
===============

MVM_LOADER -- requirements
Module: mvm_loader

Interface
REQ-001 SHALL have parameter VEC_ADDRW, default 8: vector memory address width.
REQ-002 SHALL have parameter MAT_ADDRW, default 9: per-lane matrix memory address width.
REQ-003 SHALL have parameter DATAW, default 64: packed data word width.
REQ-004 SHALL have parameter NUM_OLANES, default 8: matrix memories (power of 2); LOG_OL = log2(NUM_OLANES).
REQ-005 SHALL have parameter LOAD_SIZEW, default MAT_ADDRW+LOG_OL+1: word-count width.
REQ-006 SHALL have ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  load command strobe
- dst_mat  in  1  destination; 0=vector, 1=matrix
- start_addr  in  MAT_ADDRW  base address; low VEC_ADDRW bits used for vector
- num_words  in  LOAD_SIZEW  words to load
- in_data  in  DATAW  stream data
- in_valid  in  1  stream valid
- in_ready  out  1  stream ready
- vec_wen  out  1  vector memory write enable
- vec_waddr  out  VEC_ADDRW  vector write address
- mat_wen  out  NUM_OLANES  one-hot matrix lane write enable
- mat_waddr  out  MAT_ADDRW  matrix write address, shared by all lanes
- wdata  out  DATAW  write data, shared
- busy  out  1  load in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle rejection pulse

Function
REQ-007 SHALL implement states IDLE, LOAD, DONE.
REQ-008 IDLE: start=1 SHALL capture dst_mat, start_addr, num_words; go LOAD, or DONE if num_words==0.
REQ-009 start SHALL be ignored outside IDLE; captured values SHALL not change until the next IDLE.
REQ-010 in_ready SHALL be 1 only in LOAD; busy SHALL be 1 in LOAD and DONE.
REQ-011 A transfer SHALL occur only on a cycle with in_valid=1 and in_ready=1; word index k counts transfers from 0.
REQ-012 Vector load: transfer k SHALL write in_data to vec_waddr = (start_addr + k) mod 2^VEC_ADDRW.
REQ-013 Matrix load: transfer k SHALL write lane k mod NUM_OLANES at mat_waddr = (start_addr + (k >> LOG_OL)) mod 2^MAT_ADDRW.
REQ-014 Each write SHALL be registered: wen, waddr and wdata are valid exactly 1 cycle after the transfer, for 1 cycle.
REQ-015 vec_wen and mat_wen SHALL be 0 in any cycle not 1 cycle after a transfer; never both asserted.
REQ-016 Transfer k = num_words-1 SHALL move LOAD->DONE; in_ready drops the next cycle.
REQ-017 DONE SHALL last 1 cycle with done=1, coinciding with the final write enable; then IDLE.
REQ-018 When num_words==0, done SHALL pulse 2 cycles after start with no write enables.
REQ-019 in_valid low cycles in LOAD SHALL stall the counter; no timeout.
REQ-020 Data on in_data outside a transfer SHALL be discarded.

Reset
REQ-021 rst SHALL force IDLE; in_ready, vec_wen, mat_wen, busy, done, err = 0; vec_waddr, mat_waddr, wdata = 0; counters cleared.
REQ-022 rst during LOAD SHALL abort without done; already written words remain; pending registered write SHALL be suppressed.

Configuration
REQ-023 With LOADER_BOUNDS_CHECK_EN defined, a start whose last address exceeds memory depth SHALL be rejected.
- Vector bound: start_addr[VEC_ADDRW-1:0] + num_words > 2^VEC_ADDRW.
- Matrix bound: start_addr + ceil(num_words/NUM_OLANES) > 2^MAT_ADDRW.
- Rejection: err=1 the cycle after start, stay IDLE, no done, no writes.
REQ-024 Without LOADER_BOUNDS_CHECK_EN, err SHALL be tied 0 and addresses SHALL wrap per REQ-012/013.

Verification
REQ-025 Vector load: start, dst_mat=0, start_addr=0x10, num_words=4, continuous valid -> vec_wen at 0x10..0x13 on 4 consecutive cycles; done with last write.
REQ-026 Matrix load: dst_mat=1, start_addr=5, num_words=16, NUM_OLANES=8 -> lanes 0..7 at addr 5, then lanes 0..7 at addr 6; one-hot mat_wen.
REQ-027 Backpressure: vector load of 3 words, in_valid toggling 1,0,1,0,1 -> exactly 3 writes at consecutive addresses, each 1 cycle after its valid.
REQ-028 num_words=0 -> busy 2 cycles, done pulse, zero write enables; a start during busy is ignored.
REQ-029 rst asserted after 2 of 6 transfers -> outputs zero next cycle, no done, no further writes.
REQ-030 With LOADER_BOUNDS_CHECK_EN: vector start_addr=0xFE, num_words=4 -> err pulse, no writes. Without it: writes to 0xFE, 0xFF, 0x00, 0x01.

Source files
------------

// File: rtl/mvm_loader.sv
// Streams packed words into the vector memory or the lane-interleaved matrix memories.
// Optional: define LOADER_BOUNDS_CHECK_EN to reject loads that run past memory depth.
module mvm_loader #(
    parameter int VEC_ADDRW  = 8,
    parameter int MAT_ADDRW  = 9,
    parameter int DATAW      = 64,
    parameter int NUM_OLANES = 8,
    parameter int LOAD_SIZEW = MAT_ADDRW + $clog2(NUM_OLANES) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dst_mat,
    input  logic [MAT_ADDRW-1:0]  start_addr,
    input  logic [LOAD_SIZEW-1:0] num_words,
    input  logic [DATAW-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  vec_wen,
    output logic [VEC_ADDRW-1:0]  vec_waddr,
    output logic [NUM_OLANES-1:0] mat_wen,
    output logic [MAT_ADDRW-1:0]  mat_waddr,
    output logic [DATAW-1:0]      wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int LOG_OL = $clog2(NUM_OLANES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic                  dst_q;
    logic [MAT_ADDRW-1:0]  start_q;
    logic [LOAD_SIZEW-1:0] num_q;
    logic [LOAD_SIZEW-1:0] cnt;
    logic                  zero_q;
    logic                  done_q;
    logic                  vec_wen_q;
    logic [VEC_ADDRW-1:0]  vec_waddr_q;
    logic [NUM_OLANES-1:0] mat_wen_q;
    logic [MAT_ADDRW-1:0]  mat_waddr_q;
    logic [DATAW-1:0]      wdata_q;

    logic                  accept;
    logic                  reject;
    logic                  xfer;
    logic                  last;
    logic                  oob;
    logic [VEC_ADDRW-1:0]  vec_addr;
    logic [MAT_ADDRW-1:0]  mat_addr;
    logic [NUM_OLANES-1:0] lane_oh;

    assign last     = (cnt == num_q - LOAD_SIZEW'(1));
    assign vec_addr = start_q[VEC_ADDRW-1:0] + VEC_ADDRW'(cnt);
    assign mat_addr = start_q + MAT_ADDRW'(cnt >> LOG_OL);
    assign lane_oh  = NUM_OLANES'(1) << cnt[LOG_OL-1:0];

`ifdef LOADER_BOUNDS_CHECK_EN
    localparam int BW = LOAD_SIZEW + MAT_ADDRW + 2;

    logic [BW-1:0] vec_end;
    logic [BW-1:0] mat_rows;
    logic [BW-1:0] mat_end;
    logic          err_q;

    assign vec_end  = BW'(start_addr[VEC_ADDRW-1:0]) + BW'(num_words);
    assign mat_rows = (BW'(num_words) + BW'(NUM_OLANES - 1)) >> LOG_OL;
    assign mat_end  = BW'(start_addr) + mat_rows;
    assign oob      = dst_mat ? (mat_end > (BW'(1) << MAT_ADDRW))
                              : (vec_end > (BW'(1) << VEC_ADDRW));

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= reject;
    end

    assign err = err_q;
`else
    assign oob = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        reject  = 1'b0;
        xfer    = 1'b0;
        unique case (state)
            IDLE: begin
                // done_q still high here means a zero-length load is finishing
                if (start && !done_q) begin
                    if (oob) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_n = (num_words == '0) ? DONE : LOAD;
                    end
                end
            end
            LOAD: begin
                if (in_valid) begin
                    xfer = 1'b1;
                    if (last) state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dst_q       <= 1'b0;
            start_q     <= '0;
            num_q       <= '0;
            cnt         <= '0;
            zero_q      <= 1'b0;
            done_q      <= 1'b0;
            vec_wen_q   <= 1'b0;
            vec_waddr_q <= '0;
            mat_wen_q   <= '0;
            mat_waddr_q <= '0;
            wdata_q     <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                dst_q   <= dst_mat;
                start_q <= start_addr;
                num_q   <= num_words;
                zero_q  <= (num_words == '0);
                cnt     <= '0;
            end else if (xfer) begin
                cnt <= cnt + LOAD_SIZEW'(1);
            end
            vec_wen_q <= xfer && !dst_q;
            mat_wen_q <= (xfer && dst_q) ? lane_oh : '0;
            if (xfer) begin
                wdata_q <= in_data;
                if (dst_q) mat_waddr_q <= mat_addr;
                else       vec_waddr_q <= vec_addr;
            end
            // Aligned with the final write; zero-length loads get it from DONE.
            done_q <= (xfer && last) || (state == DONE && zero_q);
        end
    end

    assign in_ready  = (state == LOAD);
    assign busy      = (state != IDLE) || done_q;
    assign done      = done_q;
    assign vec_wen   = vec_wen_q;
    assign vec_waddr = vec_waddr_q;
    assign mat_wen   = mat_wen_q;
    assign mat_waddr = mat_waddr_q;
    assign wdata     = wdata_q;

endmodule
